sprite_draw_ctrl: RTL and testbench

// - Sequences 5x5 character-sprite blits from sprite ROM into the VGA plot interface.
// - Shares the one ROM/VGA path between two requesters (0 = player, 1 = obstacle), round-robin.
// - Scans row-major. Addresses are incremental (row_base + col, row_base += SPR_W), no multiplier.
// - Drives plot/x/y/colour with transparency, erase and screen clipping.

---
 rtl/sprite_draw_ctrl_pkg.sv | 18 +
 rtl/sprite_draw_ctrl_arbiter.sv | 30 +++
 rtl/sprite_draw_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_sprite_draw_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_draw_ctrl_pkg.sv
// Shared types and default constants for the sprite blitter.
package sprite_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int             SPR_W_DEF     = 5;
  localparam int             SPR_H_DEF     = 5;
  localparam int             SCREEN_W_DEF  = 160;
  localparam int             SCREEN_H_DEF  = 120;
  localparam logic [7:0]     TRANSP_DEF    = 8'hE3;
  localparam logic [7:0]     BG_COLOUR_DEF = 8'h00;

endpackage

// File: rtl/sprite_draw_ctrl_arbiter.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a
// tie; on advance it moves away from the requester that was just served.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       winner,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  // Grant decode and pointer update.
  always_comb begin
    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    gnt   = req;
    ptr_d = ptr_q;
    if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
    if (advance)      ptr_d = ~winner;
  end

  // Pointer flop; reset favours requester 0.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!resetn) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sprite_draw_ctrl.sv
// Sprite blit sequencer: arbitrates two requesters, scans a SPR_W x SPR_H
// sprite out of a synchronous ROM and drives the VGA plot port with
// transparency, erase and screen clipping.
module sprite_draw_ctrl
  import sprite_pkg::*;
#(
  parameter int              SPR_W     = SPR_W_DEF,
  parameter int              SPR_H     = SPR_H_DEF,
  parameter int              ADDR_W    = 5,
  parameter int              DATA_W    = 8,
  parameter int              X_W       = 8,
  parameter int              Y_W       = 7,
  parameter int              SCREEN_W  = SCREEN_W_DEF,
  parameter int              SCREEN_H  = SCREEN_H_DEF,
  parameter logic [DATA_W-1:0] TRANSP    = TRANSP_DEF,
  parameter logic [DATA_W-1:0] BG_COLOUR = BG_COLOUR_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [1:0]          req,
  input  logic [1:0]          erase,
  input  logic [2*X_W-1:0]    req_x,
  input  logic [2*Y_W-1:0]    req_y,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic                busy,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_data,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [DATA_W-1:0]   vga_colour,
  output logic                vga_plot
);

  localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(SPR_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(SPR_H - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(SPR_W);
  localparam logic [X_W:0]      X_LIMIT   = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]      Y_LIMIT   = (Y_W+1)'(SCREEN_H);

  state_e              state_q, state_d;
  logic                win_q, win_d;
  logic [X_W-1:0]      ox_q, ox_d;
  logic [Y_W-1:0]      oy_q, oy_d;
  logic                erase_q, erase_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          done_q, done_d;
  logic                busy_q, busy_d;
  // Alignment pipe: coordinates of the pixel whose ROM data arrives next cycle.
  logic                pv_q, pv_d;
  logic [X_W-1:0]      px_q, px_d;
  logic [Y_W-1:0]      py_q, py_d;
  logic                pin_q, pin_d;
  // Last plotted values, held on the VGA port while not plotting.
  logic [X_W-1:0]      lx_q, lx_d;
  logic [Y_W-1:0]      ly_q, ly_d;
  logic [DATA_W-1:0]   lc_q, lc_d;

  logic [1:0]          arb_gnt;
  logic                win_sel;
  logic [X_W:0]        cur_x;
  logic [Y_W:0]        cur_y;
  logic                cur_inb;
  logic                plot;
  logic [DATA_W-1:0]   plot_colour;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .advance (state_q == S_DONE),
    .winner  (win_q),
    .gnt     (arb_gnt)
  );

  // Screen position of the pixel currently addressed; the extra top bit
  // catches coordinate overflow so it clips instead of wrapping.
  always_comb begin
    win_sel = arb_gnt[1];
    cur_x   = {1'b0, ox_q} + (X_W+1)'(col_q);
    cur_y   = {1'b0, oy_q} + (Y_W+1)'(row_q);
    cur_inb = !cur_x[X_W] && !cur_y[Y_W] && (cur_x < X_LIMIT) && (cur_y < Y_LIMIT);
  end

  // FSM and address-counter next state.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    erase_d    = erase_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    rom_addr_d = rom_addr_q;
    gnt_d      = 2'b00;
    done_d     = 2'b00;
    busy_d     = busy_q;
    pv_d       = 1'b0;
    px_d       = px_q;
    py_d       = py_q;
    pin_d      = pin_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d    = S_SCAN;
          win_d      = win_sel;
          gnt_d      = arb_gnt;
          busy_d     = 1'b1;
          ox_d       = win_sel ? req_x[2*X_W-1:X_W] : req_x[X_W-1:0];
          oy_d       = win_sel ? req_y[2*Y_W-1:Y_W] : req_y[Y_W-1:0];
          erase_d    = erase[win_sel];
          col_d      = '0;
          row_d      = '0;
          row_base_d = '0;
          rom_addr_d = '0;
        end
      end
      S_SCAN: begin
        pv_d  = 1'b1;
        px_d  = cur_x[X_W-1:0];
        py_d  = cur_y[Y_W-1:0];
        pin_d = cur_inb;
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            state_d = S_DRAIN;
          end else begin
            row_d      = row_q + 1'b1;
            row_base_d = row_base_q + ADDR_STEP;
            rom_addr_d = row_base_q + ADDR_STEP;
          end
        end else begin
          col_d      = col_q + 1'b1;
          rom_addr_d = row_base_q + ADDR_W'(col_q) + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = win_q ? 2'b10 : 2'b01;
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Plot decision for the pixel whose ROM data is arriving now.
  always_comb begin
    plot        = pv_q && pin_q && (erase_q || (rom_data != TRANSP));
    plot_colour = erase_q ? BG_COLOUR : rom_data;
    lx_d        = plot ? px_q : lx_q;
    ly_d        = plot ? py_q : ly_q;
    lc_d        = plot ? plot_colour : lc_q;
  end

  // All sequential state; reset aborts any operation immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      win_q      <= 1'b0;
      ox_q       <= '0;
      oy_q       <= '0;
      erase_q    <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      rom_addr_q <= '0;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      busy_q     <= 1'b0;
      pv_q       <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      pin_q      <= 1'b0;
      lx_q       <= '0;
      ly_q       <= '0;
      lc_q       <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      erase_q    <= erase_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      rom_addr_q <= rom_addr_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      pv_q       <= pv_d;
      px_q       <= px_d;
      py_q       <= py_d;
      pin_q      <= pin_d;
      lx_q       <= lx_d;
      ly_q       <= ly_d;
      lc_q       <= lc_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign rom_addr   = rom_addr_q;
  assign vga_plot   = plot;
  assign vga_x      = lx_d;
  assign vga_y      = ly_d;
  assign vga_colour = lc_d;

endmodule

// File: tb/tb_sprite_draw_ctrl.sv
// Self-checking bench for sprite_draw_ctrl with a synchronous ROM model and
// a plot scoreboard fed from an independent pixel model.
module tb_sprite_draw_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  req;
  logic [1:0]  erase;
  logic [15:0] req_x;
  logic [13:0] req_y;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic        busy;
  logic [4:0]  rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [7:0]  vga_colour;
  logic        vga_plot;

  logic [7:0]  rom [0:31];
  logic [22:0] exp_q [$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          plot_cnt = 0;

  sprite_draw_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .erase      (erase),
    .req_x      (req_x),
    .req_y      (req_y),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  // Synchronous sprite ROM: data one cycle after address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Plot scoreboard: every strobe must match the next expected pixel.
  always @(negedge clk) begin : plot_mon
    logic [22:0] e;
    if (vga_plot === 1'b1) begin
      plot_cnt++;
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%h, required no plot", vga_x, vga_y, vga_colour);
      end else begin
        e = exp_q.pop_front();
        if ({vga_x, vga_y, vga_colour} !== e) begin
          n_fail++;
          $display("FAIL plot_pixel: got x=%0d y=%0d c=%h, required x=%0d y=%0d c=%h",
                   vga_x, vga_y, vga_colour, e[22:15], e[14:8], e[7:0]);
        end
      end
    end
  end

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 32; i++) rom[i] = v;
  endtask

  // Reference model: expected plots of one blit in row-major order.
  task automatic push_sprite(input int ox, input int oy, input bit er);
    int x, y;
    logic [7:0] d;
    logic [7:0] xb;
    logic [6:0] yb;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        x  = ox + c;
        y  = oy + r;
        d  = rom[r*5 + c];
        xb = x[7:0];
        yb = y[6:0];
        if (x < 160 && y < 120 && (er || d != 8'hE3))
          exp_q.push_back({xb, yb, er ? 8'h00 : d});
      end
    end
  endtask

  // Bounded observation of one operation (stimulus/sampling only).
  task automatic observe_op(input int max_cyc, input int drop_at, input bit clr_on_done,
                            output int t_gnt, output int t_done, output int n_busy,
                            output int n_gnt, output logic [1:0] g_val,
                            output logic [1:0] d_val, output bit addr_ok);
    t_gnt = -1; t_done = -1; n_busy = 0; n_gnt = 0;
    g_val = 2'b00; d_val = 2'b00; addr_ok = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (busy === 1'b1) n_busy++;
      if (gnt !== 2'b00) begin
        n_gnt++;
        if (t_gnt < 0) begin t_gnt = c; g_val = gnt; end
      end
      if (t_gnt >= 0 && (c - t_gnt) <= 24 && rom_addr !== 5'(c - t_gnt)) addr_ok = 1'b0;
      if (t_gnt >= 0 && drop_at >= 0 && (c - t_gnt) == drop_at) req = 2'b00;
      if (done !== 2'b00) begin
        t_done = c;
        d_val  = done;
        if (clr_on_done) req = 2'b00;
        break;
      end
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; req = 2'b00; erase = 2'b00; req_x = '0; req_y = '0;
    fill_rom(8'h1C);
    repeat (2) @(negedge clk);
    n_assert++;
    if ({gnt, done, busy, rom_addr, vga_x, vga_y, vga_colour, vga_plot} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b done=%b busy=%b addr=%0d x=%0d y=%0d c=%h plot=%b, required all 0",
               gnt, done, busy, rom_addr, vga_x, vga_y, vga_colour, vga_plot);
    end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({gnt, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_no_req: got gnt=%b busy=%b, required 00 0", gnt, busy);
    end
  endtask

  task automatic test_basic;
    int tg, td, nb, ng, p0; logic [1:0] gv, dv; bit ok;
    fill_rom(8'h1C);
    push_sprite(10, 20, 1'b0);
    @(negedge clk);
    req = 2'b01; erase = 2'b00; req_x = {8'd0, 8'd10}; req_y = {7'd0, 7'd20};
    p0 = plot_cnt;
    observe_op(60, -1, 1'b1, tg, td, nb, ng, gv, dv, ok);
    n_assert++; if (gv !== 2'b01) begin n_fail++; $display("FAIL basic_gnt: got %b, required 01", gv); end
    n_assert++; if (dv !== 2'b01) begin n_fail++; $display("FAIL basic_done: got %b, required 01", dv); end
    n_assert++; if (td - tg != 26) begin n_fail++; $display("FAIL basic_done_latency: got %0d, required 26", td - tg); end
    n_assert++; if (nb != 27) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d, required 27", nb); end
    n_assert++; if (plot_cnt - p0 != 25) begin n_fail++; $display("FAIL basic_plot_count: got %0d, required 25", plot_cnt - p0); end
    n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_leftover: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_transparent;
    int tg, td, nb, ng, p0; logic [1:0] gv, dv; bit ok;
    fill_rom(8'h5A);
    rom[12] = 8'hE3;
    push_sprite(40, 30, 1'b0);
    @(negedge clk);
    req = 2'b01; req_x = {8'd0, 8'd40}; req_y = {7'd0, 7'd30};
    p0 = plot_cnt;
    observe_op(60, -1, 1'b1, tg, td, nb, ng, gv, dv, ok);
    n_assert++; if (ok !== 1'b1) begin n_fail++; $display("FAIL transp_addr_seq: got broken, required 0..24"); end
    n_assert++; if (plot_cnt - p0 != 24) begin n_fail++; $display("FAIL transp_plot_count: got %0d, required 24", plot_cnt - p0); end
    n_assert++; if (td - tg != 26) begin n_fail++; $display("FAIL transp_done_latency: got %0d, required 26", td - tg); end
    n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL transp_leftover: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    int tg, td, nb, ng; logic [1:0] gv, dv, ge; bit ok;
    resetn = 1'b0; req = 2'b00;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    fill_rom(8'h1C);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push_sprite(0, 0, 1'b0);
      else            push_sprite(100, 50, 1'b0);
    end
    @(negedge clk);
    erase = 2'b00; req_x = {8'd100, 8'd0}; req_y = {7'd50, 7'd0}; req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      ge = (i % 2 == 0) ? 2'b01 : 2'b10;
      observe_op(60, -1, 1'b0, tg, td, nb, ng, gv, dv, ok);
      n_assert++; if (gv !== ge) begin n_fail++; $display("FAIL rr_gnt_%0d: got %b, required %b", i, gv, ge); end
      n_assert++; if (dv !== ge) begin n_fail++; $display("FAIL rr_done_%0d: got %b, required %b", i, dv, ge); end
      n_assert++; if (ng != 1) begin n_fail++; $display("FAIL rr_gnt_count_%0d: got %0d, required 1", i, ng); end
      n_assert++; if (td - tg != 26) begin n_fail++; $display("FAIL rr_latency_%0d: got %0d, required 26", i, td - tg); end
      if (i > 0) begin
        n_assert++; if (tg != 2) begin n_fail++; $display("FAIL rr_idle_gap_%0d: got gnt %0d cycles after done, required 2", i, tg); end
      end
    end
    req = 2'b00;
    n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_leftover: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_erase_clip;
    int tg, td, nb, ng, p0; logic [1:0] gv, dv; bit ok;
    fill_rom(8'h1C);
    push_sprite(157, 118, 1'b1);
    @(negedge clk);
    erase = 2'b10; req_x = {8'd157, 8'd0}; req_y = {7'd118, 7'd0}; req = 2'b10;
    p0 = plot_cnt;
    observe_op(60, -1, 1'b1, tg, td, nb, ng, gv, dv, ok);
    erase = 2'b00;
    n_assert++; if (gv !== 2'b10) begin n_fail++; $display("FAIL clip_gnt: got %b, required 10", gv); end
    n_assert++; if (dv !== 2'b10) begin n_fail++; $display("FAIL clip_done: got %b, required 10", dv); end
    n_assert++; if (td - tg != 26) begin n_fail++; $display("FAIL clip_latency: got %0d, required 26", td - tg); end
    n_assert++; if (plot_cnt - p0 != 6) begin n_fail++; $display("FAIL clip_plot_count: got %0d, required 6", plot_cnt - p0); end
    n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL clip_leftover: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_midop;
    int tg, td, nb, ng, p0, t0; logic [1:0] gv, dv; bit ok, bad;
    fill_rom(8'h1C);
    push_sprite(60, 70, 1'b0);
    @(negedge clk);
    req = 2'b01; req_x = {8'd0, 8'd60}; req_y = {7'd0, 7'd70};
    p0 = plot_cnt; t0 = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (gnt !== 2'b00) begin t0 = c; break; end
    end
    n_assert++; if (t0 < 0) begin n_fail++; $display("FAIL midrst_gnt: got no gnt in 10 cycles, required gnt"); end
    repeat (7) @(negedge clk);
    #2;
    resetn = 1'b0; req = 2'b00;
    #1;
    n_assert++;
    if ({gnt, done, busy, rom_addr, vga_x, vga_y, vga_colour, vga_plot} !== '0) begin
      n_fail++;
      $display("FAIL midrst_async_outputs: got gnt=%b done=%b busy=%b addr=%0d plot=%b, required all 0",
               gnt, done, busy, rom_addr, vga_plot);
    end
    n_assert++; if (plot_cnt - p0 != 7) begin n_fail++; $display("FAIL midrst_plots_before: got %0d, required 7", plot_cnt - p0); end
    exp_q.delete();
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 2'b00 || vga_plot !== 1'b0) bad = 1'b1;
    end
    n_assert++; if (bad) begin n_fail++; $display("FAIL midrst_quiet: got done/plot activity in reset, required none"); end
    resetn = 1'b1;
    push_sprite(30, 40, 1'b0);
    @(negedge clk);
    req = 2'b10; req_x = {8'd30, 8'd0}; req_y = {7'd40, 7'd0};
    observe_op(60, -1, 1'b1, tg, td, nb, ng, gv, dv, ok);
    n_assert++; if (gv !== 2'b10) begin n_fail++; $display("FAIL midrst_next_gnt: got %b, required 10", gv); end
    n_assert++; if (dv !== 2'b10) begin n_fail++; $display("FAIL midrst_next_done: got %b, required 10", dv); end
    n_assert++; if (td - tg != 26) begin n_fail++; $display("FAIL midrst_next_latency: got %0d, required 26", td - tg); end
    n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_leftover: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_req_drop;
    int tg, td, nb, ng, p0; logic [1:0] gv, dv; bit ok, bad;
    fill_rom(8'h1C);
    push_sprite(50, 60, 1'b0);
    @(negedge clk);
    req = 2'b01; req_x = {8'd0, 8'd50}; req_y = {7'd0, 7'd60};
    p0 = plot_cnt;
    observe_op(60, 3, 1'b1, tg, td, nb, ng, gv, dv, ok);
    n_assert++; if (dv !== 2'b01) begin n_fail++; $display("FAIL drop_done: got %b, required 01", dv); end
    n_assert++; if (td - tg != 26) begin n_fail++; $display("FAIL drop_latency: got %0d, required 26", td - tg); end
    n_assert++; if (plot_cnt - p0 != 25) begin n_fail++; $display("FAIL drop_plot_count: got %0d, required 25", plot_cnt - p0); end
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (gnt !== 2'b00) bad = 1'b1;
    end
    n_assert++; if (bad) begin n_fail++; $display("FAIL drop_no_regrant: got gnt with req=00, required none"); end
    n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL drop_leftover: got %0d, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_transparent;
    test_back_to_back;
    test_erase_clip;
    test_reset_midop;
    test_req_drop;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
